fpu_seq: RTL and testbench
==========================

Name: fpu_seq

Overview:
Issue/complete sequencer between the CPU execute stage and the pipelined FPU datapath.
- Registers operands and function code, then holds them stable for the FPU.
- Counts the per-function pipeline latency and captures the FPU result and exception flags into a result register.
- Presents a busy/done handshake to the core and keeps sticky exception status for software.

Parameters:
LAT_CVT, 6, cycles for int<->single conversions (FPU_CVTIS/FPU_CVTSI)
LAT_ADDSUB, 7, cycles for FPU_ADD/FPU_SUB
LAT_MUL, 5, cycles for FPU_MUL
LAT_DIV, 6, cycles for FPU_DIV
LAT_SQRT, 16, cycles for FPU_SQRT
LAT_NEG, 1, cycles for FPU_NEG
(all 1..31; counter is 5 bits)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  request; sampled only when busy_o=0
func_i  in  fpufunc_t  operation
a_i  in  32  operand 1
b_i  in  32  operand 2
flush_i  in  1  abandon in-flight op
clr_flags_i  in  1  clear sticky flags
fpu_in1_o  out  32  to FPU in1
fpu_in2_o  out  32  to FPU in2
fpu_func_o  out  fpufunc_t  to FPU func
fpu_out_i  in  32  FPU result
fpu_ov_i, fpu_un_i, fpu_nan_i, fpu_dz_i  in  1 each  FPU flags
busy_o  out  1  op in flight
done_o  out  1  one-cycle completion pulse
result_o  out  32  last captured result
flags_o  out  4  {dz,nan,un,ov} of last op
sticky_o  out  5  {illegal,dz,nan,un,ov} accumulated

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE.
  - busy_o=0, done_o=0, result_o=0, flags_o=0, sticky_o=0.
  - fpu_in1_o=fpu_in2_o=0, fpu_func_o=FPU_CVTIS.
  - Counter=0.
  - Reset mid-op discards the op; no done_o.
- States: IDLE, RUN.
- IDLE with start_i=1 at edge T:
  - Latch a_i/b_i/func_i into fpu_in1_o/fpu_in2_o/fpu_func_o.
  - cnt=LAT(func_i)-1; go RUN; busy_o=1 from T.
- RUN, each edge:
  - If flush_i: go IDLE, busy_o=0, no capture, no done_o, sticky unchanged.
  - Else if cnt==0: capture fpu_out_i→result_o and flags→flags_o; OR flags into sticky_o; done_o=1 for exactly one cycle; go IDLE, busy_o=0.
  - Else cnt--.
- Timing: capture occurs at edge T+LAT, so done_o is high in the cycle after edge T+LAT.
- FPU inputs and function stay stable from edge T until capture. The FPU cores are clocked every cycle with no enables, so stability is required.
- start_i while busy_o=1 is ignored, not queued.
- start_i in the cycle done_o=1 is accepted (state is IDLE); back-to-back ops are allowed.
- flush_i in IDLE: no effect. flush_i and cnt==0 on the same edge: flush wins.
- Unrecognised func_i encoding:
  - Latency 1; result_o=0, flags_o=0.
  - sticky_o[4] (illegal) set; done_o pulses normally.
- Flag rules for flags_o/sticky_o:
  - FPU_NEG and the conversions capture flags as 0.
  - FPU_SQRT captures ov only.
- clr_flags_i and a capture on the same edge: sticky_o = new op's flags only (clear first, then set).
- result_o and flags_o hold until the next capture; flush does not alter them.

Decomposition:
- Shared package bexkat1Def holds:
  - The existing fpufunc_t.
  - Default latency localparams FPU_LAT_* matching the parameter defaults.
  - The sticky-bit index constants (FPU_ST_OV=0, UN=1, NAN=2, DZ=3, ILL=4).
- Function→latency lookup is a function in the package, taking the parameter values as arguments.
- Sub-module fpu_lat_cnt: 5-bit loadable down-counter with zero flag. This is the natural split; the FSM and capture stay in fpu_seq.

Test Plan:
- ADD 0x3F800000 + 0x40000000, start at T → done_o at T+8 cycle, result_o=0x40400000, flags_o=0; busy_o high for cycles T+1..T+7.
- DIV 0x3F800000 / 0x00000000 → result_o=0x7F800000, flags_o[3]=1, sticky_o[3]=1. Next MUL 2.0*3.0 gives 0x40C00000 with sticky_o[3] still 1.
- SQRT in flight, second start_i (ADD) at T+3 → ignored; single done_o at T+17 with the sqrt result. Then start on the done_o cycle is accepted.
- MUL started, flush_i at T+2 → no done_o, busy_o=0 next cycle, result_o unchanged. New NEG 0x3F800000 → 0xBF800000 after 1-cycle latency.
- clr_flags_i asserted on the capture edge of a DIV-by-zero → sticky_o=5'b01000. clr_flags_i alone afterwards → sticky_o=0.
- rst_i low at T+3 of an ADD → all outputs 0 immediately, no done_o. After release, a NEG op completes normally.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the bexkat1 FPU issue/complete path.
//   fpufunc_t        : FPU function code (4-bit; codes 8..15 are unassigned)
//   FPU_LAT_*        : default pipeline latency of each FPU function
//   FPU_ST_*         : bit positions inside the sticky exception vector
//   fpu_latency()    : function code -> latency, using caller-supplied values
//   fpu_func_legal() : 1 when the function code is assigned
//   fpu_flag_mask()  : keeps only the exception flags a function can raise
package bexkat1Def;

  typedef enum logic [3:0] {
    FPU_CVTIS = 4'h0,
    FPU_CVTSI = 4'h1,
    FPU_ADD   = 4'h2,
    FPU_SUB   = 4'h3,
    FPU_MUL   = 4'h4,
    FPU_DIV   = 4'h5,
    FPU_SQRT  = 4'h6,
    FPU_NEG   = 4'h7
  } fpufunc_t;

  localparam int unsigned FPU_LAT_CVT    = 6;
  localparam int unsigned FPU_LAT_ADDSUB = 7;
  localparam int unsigned FPU_LAT_MUL    = 5;
  localparam int unsigned FPU_LAT_DIV    = 6;
  localparam int unsigned FPU_LAT_SQRT   = 16;
  localparam int unsigned FPU_LAT_NEG    = 1;

  localparam int FPU_ST_OV  = 0;
  localparam int FPU_ST_UN  = 1;
  localparam int FPU_ST_NAN = 2;
  localparam int FPU_ST_DZ  = 3;
  localparam int FPU_ST_ILL = 4;

  function automatic logic [4:0] fpu_latency(
    input fpufunc_t    f,
    input int unsigned lat_cvt,
    input int unsigned lat_addsub,
    input int unsigned lat_mul,
    input int unsigned lat_div,
    input int unsigned lat_sqrt,
    input int unsigned lat_neg
  );
    logic [4:0] lat;
    case (f)
      FPU_CVTIS, FPU_CVTSI: lat = lat_cvt[4:0];
      FPU_ADD, FPU_SUB:     lat = lat_addsub[4:0];
      FPU_MUL:              lat = lat_mul[4:0];
      FPU_DIV:              lat = lat_div[4:0];
      FPU_SQRT:             lat = lat_sqrt[4:0];
      FPU_NEG:              lat = lat_neg[4:0];
      default:              lat = 5'd1;
    endcase
    return lat;
  endfunction

  function automatic logic fpu_func_legal(input fpufunc_t f);
    logic ok;
    case (f)
      FPU_CVTIS, FPU_CVTSI, FPU_ADD, FPU_SUB,
      FPU_MUL, FPU_DIV, FPU_SQRT, FPU_NEG: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // raw is {dz,nan,un,ov}; sign change and conversions never raise flags,
  // and the square-root core only reports overflow.
  function automatic logic [3:0] fpu_flag_mask(input fpufunc_t f, input logic [3:0] raw);
    logic [3:0] m;
    case (f)
      FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV: m = raw;
      FPU_SQRT:                           m = {3'b000, raw[FPU_ST_OV]};
      default:                            m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fpu_seq_lat_cnt.sv
// fpu_lat_cnt: 5-bit loadable down-counter with zero flag.
//   clk_i, rst_i (async, active-low)
//   load_i / load_val_i : load a new count (has priority over dec_i)
//   dec_i               : decrement by one
//   cnt_o / zero_o      : current count and (count == 0)
module fpu_lat_cnt (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [4:0] load_val_i,
  input  logic       dec_i,
  output logic [4:0] cnt_o,
  output logic       zero_o
);

  logic [4:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = load_val_i;
    else if (dec_i) cnt_d = cnt_q - 5'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= 5'd0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == 5'd0);

endmodule

// File: rtl/fpu_seq.sv
// fpu_seq: issue/complete sequencer between the execute stage and the FPU.
//   clk_i, rst_i (async, active-low)
//   start_i/func_i/a_i/b_i : operation request, taken only while idle
//   flush_i                : abandon the in-flight operation
//   clr_flags_i            : clear sticky exception status
//   fpu_in1_o/fpu_in2_o/fpu_func_o : operands and function held for the FPU
//   fpu_out_i, fpu_{ov,un,nan,dz}_i: FPU result and exception flags
//   busy_o, done_o         : operation in flight / one-cycle completion pulse
//   result_o, flags_o      : last captured result and {dz,nan,un,ov}
//   sticky_o               : accumulated {illegal,dz,nan,un,ov}
module fpu_seq
  import bexkat1Def::*;
#(
  parameter int unsigned LAT_CVT    = FPU_LAT_CVT,
  parameter int unsigned LAT_ADDSUB = FPU_LAT_ADDSUB,
  parameter int unsigned LAT_MUL    = FPU_LAT_MUL,
  parameter int unsigned LAT_DIV    = FPU_LAT_DIV,
  parameter int unsigned LAT_SQRT   = FPU_LAT_SQRT,
  parameter int unsigned LAT_NEG    = FPU_LAT_NEG
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  fpufunc_t    func_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  input  logic        clr_flags_i,
  output logic [31:0] fpu_in1_o,
  output logic [31:0] fpu_in2_o,
  output fpufunc_t    fpu_func_o,
  input  logic [31:0] fpu_out_i,
  input  logic        fpu_ov_i,
  input  logic        fpu_un_i,
  input  logic        fpu_nan_i,
  input  logic        fpu_dz_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [3:0]  flags_o,
  output logic [4:0]  sticky_o
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] in1_q, in1_d, in2_q, in2_d;
  fpufunc_t    func_q, func_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic [4:0]  sticky_q, sticky_d;

  logic        cnt_load, cnt_dec, cnt_zero;
  logic [4:0]  cnt_val, cnt_cur;
  logic [3:0]  raw_flags;

  assign raw_flags = {fpu_dz_i, fpu_nan_i, fpu_un_i, fpu_ov_i};
  // Latency is at least 1, so the load value never underflows.
  assign cnt_val   = fpu_latency(func_i, LAT_CVT, LAT_ADDSUB, LAT_MUL,
                                 LAT_DIV, LAT_SQRT, LAT_NEG) - 5'd1;

  fpu_lat_cnt u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_cur),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    func_d   = func_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    // Clear is applied before any capture so a same-edge capture survives.
    sticky_d = clr_flags_i ? 5'd0 : sticky_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          in1_d    = a_i;
          in2_d    = b_i;
          func_d   = func_i;
          cnt_load = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_zero) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (fpu_func_legal(func_q)) begin
            result_d      = fpu_out_i;
            flags_d       = fpu_flag_mask(func_q, raw_flags);
            sticky_d[3:0] = sticky_d[3:0] | flags_d;
          end else begin
            result_d             = 32'd0;
            flags_d              = 4'd0;
            sticky_d[FPU_ST_ILL] = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      in1_q    <= 32'd0;
      in2_q    <= 32'd0;
      func_q   <= FPU_CVTIS;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      flags_q  <= 4'd0;
      sticky_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      func_q   <= func_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
    end
  end

  assign busy_o     = (state_q == S_RUN);
  assign done_o     = done_q;
  assign fpu_in1_o  = in1_q;
  assign fpu_in2_o  = in2_q;
  assign fpu_func_o = func_q;
  assign result_o   = result_q;
  assign flags_o    = flags_q;
  assign sticky_o   = sticky_q;

  // The counter value itself is only observed through its zero flag.
  logic unused_cnt;
  assign unused_cnt = ^cnt_cur;

endmodule

// File: tb/tb_fpu_seq.sv
module tb_fpu_seq;
  import bexkat1Def::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, flush_i, clr_flags_i;
  fpufunc_t    func_i;
  logic [31:0] a_i, b_i, fpu_out_i;
  logic        fpu_ov_i, fpu_un_i, fpu_nan_i, fpu_dz_i;
  logic [31:0] fpu_in1_o, fpu_in2_o, result_o;
  fpufunc_t    fpu_func_o;
  logic        busy_o, done_o;
  logic [3:0]  flags_o;
  logic [4:0]  sticky_o;

  always #5 clk = ~clk;

  fpu_seq dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .func_i(func_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .clr_flags_i(clr_flags_i),
    .fpu_in1_o(fpu_in1_o), .fpu_in2_o(fpu_in2_o), .fpu_func_o(fpu_func_o),
    .fpu_out_i(fpu_out_i), .fpu_ov_i(fpu_ov_i), .fpu_un_i(fpu_un_i),
    .fpu_nan_i(fpu_nan_i), .fpu_dz_i(fpu_dz_i), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o), .flags_o(flags_o), .sticky_o(sticky_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Reference model: an accepted op completes at a fixed edge number
  // (acceptance edge + latency) unless flushed or reset first.
  int          n_edge;
  bit          m_busy, m_done;
  int          m_deadline;
  logic [3:0]  m_func;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_flags;
  logic [4:0]  m_sticky;

  localparam logic [3:0] F_CVTIS = 4'h0, F_CVTSI = 4'h1, F_ADD = 4'h2, F_SUB = 4'h3,
                         F_MUL = 4'h4, F_DIV = 4'h5, F_SQRT = 4'h6, F_NEG = 4'h7;

  function automatic int lat_tb(input logic [3:0] f);
    case (f)
      F_CVTIS, F_CVTSI: return 6;
      F_ADD, F_SUB:     return 7;
      F_MUL:            return 5;
      F_DIV:            return 6;
      F_SQRT:           return 16;
      F_NEG:            return 1;
      default:          return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_func = F_CVTIS; m_a = 0; m_b = 0;
    m_res = 0; m_flags = 0; m_sticky = 0; m_deadline = 0;
  endtask

  task automatic check_all();
    check_eq("busy",   {31'd0, busy_o}, {31'd0, m_busy});
    check_eq("done",   {31'd0, done_o}, {31'd0, m_done});
    check_eq("result", result_o, m_res);
    check_eq("flags",  {28'd0, flags_o}, {28'd0, m_flags});
    check_eq("sticky", {27'd0, sticky_o}, {27'd0, m_sticky});
    check_eq("in1",    fpu_in1_o, m_a);
    check_eq("in2",    fpu_in2_o, m_b);
    check_eq("func",   {28'd0, 4'(fpu_func_o)}, {28'd0, m_func});
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare after it.
  // fx is {dz,nan,un,ov} as presented by the FPU.
  task automatic step(input bit st, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input bit fl, input bit clr, input logic [31:0] out, input logic [3:0] fx);
    bit cap;
    start_i = st; func_i = fpufunc_t'(f); a_i = a; b_i = b;
    flush_i = fl; clr_flags_i = clr; fpu_out_i = out;
    {fpu_dz_i, fpu_nan_i, fpu_un_i, fpu_ov_i} = fx;
    @(posedge clk);
    n_edge++;
    cap = 0;
    m_done = 0;
    if (m_busy) begin
      if (fl) m_busy = 0;
      else if (n_edge == m_deadline) cap = 1;
    end else if (st) begin
      m_busy = 1; m_func = f; m_a = a; m_b = b; m_deadline = n_edge + lat_tb(f);
    end
    if (clr) m_sticky = 0;
    if (cap) begin
      m_busy = 0; m_done = 1;
      case (m_func)
        F_ADD, F_SUB, F_MUL, F_DIV: begin m_res = out; m_flags = fx; end
        F_SQRT:                     begin m_res = out; m_flags = {3'b000, fx[0]}; end
        F_CVTIS, F_CVTSI, F_NEG:    begin m_res = out; m_flags = 4'b0000; end
        default: begin m_res = 0; m_flags = 0; m_sticky[4] = 1'b1; end
      endcase
      m_sticky[3:0] = m_sticky[3:0] | m_flags;
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int k, input logic [31:0] out, input logic [3:0] fx);
    for (int i = 0; i < k; i++) step(0, F_CVTIS, 0, 0, 0, 0, out, fx);
  endtask

  task automatic wait_done(input logic [31:0] out, input logic [3:0] fx);
    for (int i = 0; i < 40 && !m_done; i++) step(0, F_CVTIS, 0, 0, 0, 0, out, fx);
  endtask

  task automatic op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] out, input logic [3:0] fx);
    step(1, f, a, b, 0, 0, out, fx);
    wait_done(out, fx);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    start_i = 0; flush_i = 0; clr_flags_i = 0;
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_edge = 0;
    rst_n = 1; start_i = 0; flush_i = 0; clr_flags_i = 0; func_i = FPU_CVTIS;
    a_i = 0; b_i = 0; fpu_out_i = 0;
    {fpu_dz_i, fpu_nan_i, fpu_un_i, fpu_ov_i} = 4'b0;
    #3;
    do_reset();

    // ADD 1.0 + 2.0 = 3.0
    op(F_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000);
    // DIV by zero, then MUL keeps sticky dz
    op(F_DIV, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b1000);
    op(F_MUL, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
    // SQRT with an ignored second start, then start on the done cycle
    step(1, F_SQRT, 32'h40800000, 0, 0, 0, 32'h40000000, 4'b0001);
    idle(2, 32'h40000000, 4'b0001);
    step(1, F_ADD, 32'h11111111, 32'h22222222, 0, 0, 32'h40000000, 4'b0001);
    wait_done(32'h40000000, 4'b1111);
    op(F_NEG, 32'h3F800000, 0, 32'hBF800000, 4'b1111);
    // MUL flushed two cycles in, then NEG
    step(1, F_MUL, 32'h40000000, 32'h40000000, 0, 0, 32'h40800000, 4'b0000);
    step(0, F_CVTIS, 0, 0, 0, 0, 32'h40800000, 4'b0000);
    step(0, F_CVTIS, 0, 0, 1, 0, 32'h40800000, 4'b0000);
    idle(3, 32'h40800000, 4'b0000);
    op(F_NEG, 32'h3F800000, 0, 32'hBF800000, 4'b0000);
    // Clear coinciding with a DIV-by-zero capture, then clear alone
    step(1, F_DIV, 32'h3F800000, 0, 0, 0, 32'h7F800000, 4'b1000);
    idle(5, 32'h7F800000, 4'b1000);
    step(0, F_CVTIS, 0, 0, 0, 1, 32'h7F800000, 4'b1000);
    check_eq("clr_on_capture", {27'd0, sticky_o}, 32'h08);
    step(0, F_CVTIS, 0, 0, 0, 1, 0, 4'b0000);
    check_eq("clr_alone", {27'd0, sticky_o}, 32'h00);
    // Illegal function code
    op(4'hB, 32'h1234, 32'h5678, 32'hDEADBEEF, 4'b1111);
    // Reset in the middle of an ADD, then NEG
    step(1, F_ADD, 32'h3F800000, 32'h40000000, 0, 0, 32'h40400000, 4'b0000);
    idle(2, 32'h40400000, 4'b0000);
    do_reset();
    op(F_NEG, 32'h3F800000, 0, 32'hBF800000, 4'b0000);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] f;
      f = 4'($urandom_range(0, 9));
      if (f > 4'd7) f = 4'($urandom_range(8, 15));
      step(($urandom % 3) == 0, f, $urandom, $urandom, ($urandom % 16) == 0,
           ($urandom % 20) == 0, $urandom, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
